// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected on completion.
// Fixed 34-cycle round trip (1 accept + 32 iterations + 1 finish), with
// per-hart flush and hart/rd tags echoed on the done pulse.
module muldiv_iter_unit #(
   parameter int XLEN   = 32,
   parameter int HART_W = 1,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [HART_W-1:0] hart_id,
   input  logic [4:0]        rd,
   input  logic              flush,
   input  logic [HART_W-1:0] flush_hart,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic [HART_W-1:0] done_hart_id,
   output logic [4:0]        done_rd
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t              r_state, w_next;
   logic [2:0]          r_op;
   logic [XLEN-1:0]     r_hi, r_lo, r_opb;
   logic                r_neg_q, r_neg_r, r_dz;
   logic [HART_W-1:0]   r_hart;
   logic [4:0]          r_rd;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_sa, w_sb, w_accept, w_flush_hit, w_last;
   logic [XLEN-1:0]     w_mag_a, w_mag_b;
   logic [XLEN:0]       w_sum, w_shift;
   logic                w_ge;
   logic [XLEN-1:0]     w_trial, w_hi_n, w_lo_n;
   logic [2*XLEN-1:0]   w_prod, w_prod_c;
   logic [XLEN-1:0]     w_quo, w_rem, w_sel;

   // Operand decode: signedness per funct3 and magnitudes for the iteration.
   always_comb begin
      w_sa        = a[XLEN-1] & (op[2] ? ~op[0] : (op == 3'd1 || op == 3'd2));
      w_sb        = b[XLEN-1] & (op[2] ? ~op[0] : (op == 3'd1));
      w_mag_a     = w_sa ? -a : a;
      w_mag_b     = w_sb ? -b : b;
      // A same-hart flush cancels a start arriving in the same cycle.
      w_accept    = start & (r_state == S_IDLE) & ~(flush & (flush_hart == hart_id));
      w_flush_hit = flush & (flush_hart == r_hart) & (r_state != S_IDLE);
      w_last      = (r_cnt == CNT_W'(XLEN - 1));
   end

   // One radix-2 step: {r_hi,r_lo} is the product (mul) or remainder/quotient (div).
   always_comb begin
      w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : '0)};
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_ge    = (w_shift >= {1'b0, r_opb});
      w_trial = w_shift[XLEN-1:0] - r_opb;
      if (r_op[2]) begin
         w_hi_n = w_ge ? w_trial : w_shift[XLEN-1:0];
         w_lo_n = {r_lo[XLEN-2:0], w_ge};
      end else begin
         w_hi_n = w_sum[XLEN:1];
         w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   // Sign correction and result selection, gated to zero outside the done pulse.
   always_comb begin
      w_prod   = {r_hi, r_lo};
      w_prod_c = r_neg_q ? -w_prod : w_prod;
      w_quo    = r_dz ? '1 : (r_neg_q ? -r_lo : r_lo);
      w_rem    = r_neg_r ? -r_hi : r_hi;
      case (r_op)
         3'd0:       w_sel = w_prod_c[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:       w_sel = w_prod_c[2*XLEN-1:XLEN];
         3'd4, 3'd5: w_sel = w_quo;
         default:    w_sel = w_rem;
      endcase
      result       = done ? w_sel  : '0;
      done_hart_id = done ? r_hart : '0;
      done_rd      = done ? r_rd   : '0;
   end

   // Next-state logic and status outputs.
   always_comb begin
      w_next = r_state;
      busy   = (r_state != S_IDLE);
      done   = (r_state == S_FIN) & ~w_flush_hit;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_CALC;
         S_CALC:  if (w_flush_hit) w_next = S_IDLE;
                  else if (w_last) w_next = S_FIN;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Datapath: latch operands and tags on accept, iterate while in CALC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_opb   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_hart  <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_op    <= op;
         r_hi    <= '0;
         r_lo    <= w_mag_a;
         r_opb   <= w_mag_b;
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
         r_dz    <= op[2] & (b == '0);
         r_hart  <= hart_id;
         r_rd    <= rd;
         r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
         r_hi    <= w_hi_n;
         r_lo    <= w_lo_n;
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: directed corner cases plus
// random operations against an arithmetic reference model.
module tb_muldiv_iter_unit;

   localparam int XLEN   = 32;
   localparam int HART_W = 1;

   logic              clk = 1'b0;
   logic              rst_n, start, flush;
   logic [2:0]        op;
   logic [XLEN-1:0]   a, b;
   logic [HART_W-1:0] hart_id, flush_hart;
   logic [4:0]        rd;
   logic              busy, done;
   logic [XLEN-1:0]   result;
   logic [HART_W-1:0] done_hart_id;
   logic [4:0]        done_rd;

   muldiv_iter_unit #(.XLEN(XLEN), .HART_W(HART_W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .hart_id(hart_id), .rd(rd), .flush(flush), .flush_hart(flush_hart),
      .busy(busy), .done(done), .result(result),
      .done_hart_id(done_hart_id), .done_rd(done_rd)
   );

   always #5 clk = ~clk;

   int ncmp = 0, nfail = 0;
   int cyc, ndone, first_done, nz;
   logic [XLEN-1:0]   got_res;
   logic [HART_W-1:0] got_hart;
   logic [4:0]        got_rd;
   logic              busy_at [0:63];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain RV32M arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      case (f)
         3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
         3'd1: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
         3'd2: begin p = longint'(sx) * longint'({32'd0, y}); return p[63:32]; end
         3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFFFFFF;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
            return sx / sy;
         end
         3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
            return sx % sy;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Advance to the next falling edge and record what the DUT shows there.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (cyc < 64) busy_at[cyc] = busy;
      if (done === 1'b1) begin
         ndone++;
         if (ndone == 1) begin
            first_done = cyc;
            got_res    = result;
            got_hart   = done_hart_id;
            got_rd     = done_rd;
         end
      end else if (result != 0 || done_hart_id != 0 || done_rd != 0) begin
         nz++;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   // Present a start at the current falling edge (cycle 0), then scramble operands.
   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [HART_W-1:0] h, input logic [4:0] r);
      cyc = 0; ndone = 0; nz = 0; first_done = -1;
      got_res = '0; got_hart = '0; got_rd = '0;
      foreach (busy_at[i]) busy_at[i] = 1'bx;
      start = 1'b1; op = f; a = x; b = y; hart_id = h; rd = r;
      step();
      start = 1'b0; a = $urandom; b = $urandom; hart_id = ~h; rd = $urandom;
   endtask

   task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] x,
                           input logic [31:0] y, input logic [HART_W-1:0] h, input logic [4:0] r);
      issue(f, x, y, h, r);
      run_to(34);
      chk({tag, ".ndone"}, 64'(ndone), 64'd1);
      chk({tag, ".lat"}, 64'(first_done), 64'd33);
      chk({tag, ".res"}, 64'(got_res), 64'(ref_res(f, x, y)));
      chk({tag, ".hart"}, 64'(got_hart), 64'(h));
      chk({tag, ".rd"}, 64'(got_rd), 64'(r));
      chk({tag, ".busy34"}, 64'(busy_at[34]), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; flush_hart = '0;
      op = '0; a = '0; b = '0; hart_id = '0; rd = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.result", 64'(result), 64'd0);
      chk("rst.hart", 64'(done_hart_id), 64'd0);
      chk("rst.rd", 64'(done_rd), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MUL 10*3 with full latency/busy profile
      op_check("mul10x3", 3'd0, 32'd10, 32'd3, 1'b0, 5'd3);
      chk("mul10x3.res30", 64'(got_res), 64'd30);
      chk("mul10x3.busy1", 64'(busy_at[1]), 64'd1);
      chk("mul10x3.busy33", 64'(busy_at[33]), 64'd1);
      chk("mul10x3.zero_idle", 64'(nz), 64'd0);

      op_check("div10_3", 3'd4, 32'd10, 32'd3, 1'b0, 5'd1);
      chk("div10_3.abs", 64'(got_res), 64'd3);
      op_check("rem10_3", 3'd6, 32'd10, 32'd3, 1'b1, 5'd2);
      chk("rem10_3.abs", 64'(got_res), 64'd1);
      op_check("divm7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 5'd4);
      chk("divm7_2.abs", 64'(got_res), 64'hFFFFFFFD);
      op_check("remm7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, 5'd5);
      chk("remm7_2.abs", 64'(got_res), 64'hFFFFFFFF);
      op_check("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd6);
      chk("mulhu.abs", 64'(got_res), 64'hFFFFFFFE);
      op_check("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd7);
      chk("mulh.abs", 64'(got_res), 64'd0);
      op_check("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd8);
      chk("mulhsu.abs", 64'(got_res), 64'hFFFFFFFF);
      op_check("divu_0", 3'd5, 32'd1234, 32'd0, 1'b0, 5'd9);
      chk("divu_0.abs", 64'(got_res), 64'hFFFFFFFF);
      op_check("rem5_0", 3'd6, 32'd5, 32'd0, 1'b0, 5'd10);
      chk("rem5_0.abs", 64'(got_res), 64'd5);
      op_check("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5'd11);
      chk("div_ovf.abs", 64'(got_res), 64'h80000000);
      op_check("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5'd12);
      chk("rem_ovf.abs", 64'(got_res), 64'd0);
      op_check("div_neg0", 3'd4, 32'hFFFFFFF0, 32'd0, 1'b0, 5'd13);

      // Second start while busy is ignored; start in cycle 34 is accepted
      issue(3'd0, 32'd7, 32'd6, 1'b0, 5'd5);
      run_to(9);
      start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; hart_id = 1'b1; rd = 5'd9;
      step();
      start = 1'b0;
      run_to(34);
      chk("ign.ndone", 64'(ndone), 64'd1);
      chk("ign.lat", 64'(first_done), 64'd33);
      chk("ign.res", 64'(got_res), 64'd42);
      chk("ign.hart", 64'(got_hart), 64'd0);
      chk("ign.rd", 64'(got_rd), 64'd5);
      op_check("c34", 3'd5, 32'd100, 32'd7, 1'b1, 5'd9);

      // Same-hart flush in CALC at cycle 20
      issue(3'd4, 32'd1000, 32'd7, 1'b0, 5'd3);
      run_to(20);
      flush = 1'b1; flush_hart = 1'b0;
      step();
      flush = 1'b0;
      run_to(40);
      chk("flush.busy20", 64'(busy_at[20]), 64'd1);
      chk("flush.busy21", 64'(busy_at[21]), 64'd0);
      chk("flush.ndone", 64'(ndone), 64'd0);

      // Other-hart flush has no effect
      issue(3'd0, 32'd123, 32'd456, 1'b0, 5'd14);
      run_to(20);
      flush = 1'b1; flush_hart = 1'b1;
      step();
      flush = 1'b0;
      run_to(34);
      chk("oflush.ndone", 64'(ndone), 64'd1);
      chk("oflush.lat", 64'(first_done), 64'd33);
      chk("oflush.res", 64'(got_res), 64'd56088);

      // Same-hart flush while in FIN suppresses the done pulse
      issue(3'd0, 32'd9, 32'd9, 1'b1, 5'd15);
      run_to(32);
      @(posedge clk); #1;
      flush = 1'b1; flush_hart = 1'b1;
      step();
      flush = 1'b0;
      run_to(40);
      chk("finflush.ndone", 64'(ndone), 64'd0);
      chk("finflush.busy34", 64'(busy_at[34]), 64'd0);

      // Start together with same-hart flush is dropped; different hart is accepted
      flush = 1'b1; flush_hart = 1'b0;
      issue(3'd0, 32'd2, 32'd2, 1'b0, 5'd1);
      flush = 1'b0;
      run_to(40);
      chk("sflush.busy1", 64'(busy_at[1]), 64'd0);
      chk("sflush.ndone", 64'(ndone), 64'd0);
      flush = 1'b1; flush_hart = 1'b1;
      issue(3'd0, 32'd2, 32'd5, 1'b0, 5'd1);
      flush = 1'b0;
      run_to(34);
      chk("dflush.ndone", 64'(ndone), 64'd1);
      chk("dflush.res", 64'(got_res), 64'd10);

      // Reset mid-operation abandons it
      issue(3'd6, 32'd77, 32'd5, 1'b0, 5'd2);
      run_to(15);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      run_to(40);
      chk("rstmid.busy16", 64'(busy_at[16]), 64'd0);
      chk("rstmid.ndone", 64'(ndone), 64'd0);
      chk("rstmid.zero", 64'(nz), 64'd0);

      // Random operations
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  rf;
         logic [31:0] ra, rb;
         int          sel;
         rf  = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = '0;
         else if (sel == 1) rb = 32'($urandom_range(1, 15));
         else if (sel == 2) rb = 32'hFFFFFFFF;
         if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
         op_check($sformatf("rnd%0d", i), rf, ra, rb, 1'($urandom), 5'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
